// File: rtl/gbuf_skew_reader.sv
// gbuf_skew_reader: reads k_len consecutive words from the global buffer and
// re-times them into a diagonally skewed byte-per-lane stream (lane i delayed
// by i cycles) for the systolic array input edge.
module gbuf_skew_reader #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LANES     = 4,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS-1:0] k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 gbuf_en,
  output logic                 gbuf_wr_en,
  output logic [ADDR_BITS-1:0] gbuf_index,
  input  logic [DATA_BITS-1:0] gbuf_rdata,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);
  // Drain covers the deepest lane plus the capture register.
  localparam logic [ADDR_BITS-1:0] DRAIN_CNT = ADDR_BITS'(LANES);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] cap_q;
  logic [LANES-1:0]     vld_q;

  // Sequencer state, remaining-cycle counter and read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; cnt counts down remaining cycles of READ / DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_d = READ;
            cnt_d   = k_len - ONE;
            idx_d   = base_addr;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_CNT;
        end else begin
          cnt_d = cnt_q - ONE;
          idx_d = idx_q + ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gbuf_en    = (state_q == READ);
  assign busy       = (state_q == READ) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign gbuf_wr_en = 1'b0;
  assign gbuf_index = idx_q;

  // Capture the returned word; non-read cycles load zeros so every lane
  // naturally emits 0x00 outside its data window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      vld_q <= '0;
    end else begin
      cap_q <= gbuf_en ? gbuf_rdata : '0;
      vld_q <= {vld_q[LANES-2:0], gbuf_en};
    end
  end

  assign out_data[7:0] = cap_q[7:0];
  assign out_valid     = |vld_q;

  for (genvar i = 1; i < LANES; i++) begin : g_lane
    logic [7:0] sr_q [i];

    // Lane i: i-deep byte shift register behind the capture register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < i; k++) sr_q[k] <= '0;
      end else begin
        sr_q[0] <= cap_q[8*i +: 8];
        for (int unsigned k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
      end
    end

    assign out_data[8*i +: 8] = sr_q[i-1];
  end

endmodule

// File: tb/tb_gbuf_skew_reader.sv
// Bench for gbuf_skew_reader: directed scenarios plus random transfers,
// checked cycle by cycle against a timeline model of the skewed stream.
module tb_gbuf_skew_reader;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] k_len = '0;
  logic        busy, done, gbuf_en, gbuf_wr_en, out_valid;
  logic [11:0] gbuf_index;
  logic [31:0] gbuf_rdata = '0;
  logic [31:0] out_data;

  logic [31:0] mem [4096];
  int unsigned total = 0;
  int unsigned passed = 0;
  logic [11:0] exp_idx = '0;

  gbuf_skew_reader #(.ADDR_BITS(12), .LANES(4), .DATA_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .k_len(k_len), .busy(busy), .done(done), .gbuf_en(gbuf_en),
    .gbuf_wr_en(gbuf_wr_en), .gbuf_index(gbuf_index),
    .gbuf_rdata(gbuf_rdata), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Buffer model: read data updates on the falling edge.
  always @(negedge clk) if (gbuf_en) gbuf_rdata <= mem[gbuf_index];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
  endtask

  // Byte i of word j shows up in cycle 2+j+i.
  function automatic logic [31:0] exp_data(logic [11:0] b, int k, int t);
    logic [31:0] d = '0;
    logic [11:0] a;
    logic [31:0] w;
    for (int i = 0; i < L; i++) begin
      int j = t - 2 - i;
      if (j >= 0 && j < k) begin
        a = b + 12'(j);
        w = mem[a];
        d[8*i +: 8] = w[8*i +: 8];
      end
    end
    return d;
  endfunction

  task automatic check_zero(string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " en"}, 32'(gbuf_en), 0);
    chk({tag, " wr"}, 32'(gbuf_wr_en), 0);
    chk({tag, " idx"}, 32'(gbuf_index), 32'(exp_idx));
    chk({tag, " data"}, out_data, 0);
    chk({tag, " valid"}, 32'(out_valid), 0);
  endtask

  task automatic check_cycle(string tag, logic [11:0] b, int k, int t);
    string p = $sformatf("%s t%0d", tag, t);
    int done_t = (k == 0) ? 1 : k + L + 2;
    if (t >= 1 && t <= k) exp_idx = b + 12'(t - 1);
    chk({p, " busy"}, 32'(busy), 32'(k > 0 && t >= 1 && t <= k + L + 1));
    chk({p, " done"}, 32'(done), 32'(t == done_t));
    chk({p, " en"}, 32'(gbuf_en), 32'(t >= 1 && t <= k));
    chk({p, " wr"}, 32'(gbuf_wr_en), 0);
    chk({p, " idx"}, 32'(gbuf_index), 32'(exp_idx));
    chk({p, " data"}, out_data, exp_data(b, k, t));
    chk({p, " valid"}, 32'(out_valid), 32'(k > 0 && t >= 2 && t <= k + L));
  endtask

  // One transfer from its start cycle through its done cycle. restart_at pulses
  // a stray start; reset_at asserts rst_n in that cycle and abandons the run.
  task automatic run(string tag, logic [11:0] b, int k, int restart_at, int reset_at);
    int last = (k == 0) ? 1 : k + L + 2;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; k_len = 12'(k);
    check_cycle(tag, b, k, 0);
    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      start = (t == restart_at);
      base_addr = 12'($urandom);
      k_len = 12'($urandom_range(0, 20));
      if (t == reset_at) begin
        rst_n = 1'b0;
        #1;
        exp_idx = '0;
        check_zero({tag, " rst"});
        #2 rst_n = 1'b1;
        start = 1'b0;
        for (int c = 0; c < k + L + 3; c++) begin
          @(posedge clk); #1;
          check_zero({tag, " post"});
        end
        return;
      end
      check_cycle(tag, b, k, t);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h03020100; mem[1] = 32'h07060504;
    mem[2] = 32'h0B0A0908; mem[3] = 32'h0F0E0D0C;

    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_zero("idle");
    end

    run("basic", 12'h000, 4, 0, 0);
    run("wrap", 12'hFFE, 4, 0, 0);
    run("zero", 12'h123, 0, 0, 0);
    run("restart", 12'h000, 4, 3, 0);
    run("next", 12'h040, 5, 0, 0);
    run("abort", 12'h200, 8, 0, 4);
    run("after", 12'h300, 4, 0, 0);

    for (int r = 0; r < 12; r++) begin
      run($sformatf("rnd%0d", r), 12'($urandom), int'($urandom_range(0, 20)),
          int'($urandom_range(1, 6)), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
